// File: rtl/embcpu8k_oci_dct_pkg.sv
// Shared widths and state type for the OCI trace packer.
package embcpu8k_oci_dct_pkg;

  localparam int unsigned DCT_ATOM_W = 2;
  localparam int unsigned DCT_DEPTH  = 15;
  localparam int unsigned DCT_BUF_W  = 30;
  localparam int unsigned DCT_CNT_W  = 4;
  localparam int unsigned DCT_DROP_W = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } dct_state_e;

endpackage

// File: rtl/embcpu8k_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit trace atoms into 15-slot frames handed off with a valid/ready pair.
// Optional macro DCT_DROP_CNT_EN adds a saturating dropped-atom counter port.
module embcpu8k_nios2_qsys_0_oci_dct_packer
  import embcpu8k_oci_dct_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  atom_valid,
  input  logic [DCT_ATOM_W-1:0] atom_data,
  input  logic                  flush,
  input  logic                  test_ending,
  input  logic                  dct_ready,
  output logic                  dct_valid,
  output logic [DCT_BUF_W-1:0]  dct_buffer,
  output logic [DCT_CNT_W-1:0]  dct_count,
`ifdef DCT_DROP_CNT_EN
  output logic [DCT_DROP_W-1:0] dropped_cnt,
`endif
  output logic                  test_has_ended
);

  dct_state_e           r_state;
  dct_state_e           w_state_nxt;
  logic [DCT_BUF_W-1:0] r_buf;
  logic [DCT_BUF_W-1:0] w_buf_nxt;
  logic [DCT_CNT_W-1:0] r_cnt;
  logic [DCT_CNT_W-1:0] w_cnt_nxt;
  logic                 r_ending;
  logic                 w_ending;
  logic                 w_close;
  logic                 r_dct_valid;
  logic                 r_test_has_ended;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_EMPTY;
    else          r_state <= w_state_nxt;
  end

  // Next state and next frame contents; an atom is appended before any close.
  always_comb begin
    w_state_nxt = r_state;
    w_buf_nxt   = r_buf;
    w_cnt_nxt   = r_cnt;
    w_close     = 1'b0;
    w_ending    = r_ending | test_ending;
    case (r_state)
      ST_EMPTY, ST_FILL: begin
        if (atom_valid) begin
          for (int unsigned k = 0; k < DCT_DEPTH; k++) begin
            if (r_cnt == DCT_CNT_W'(k)) w_buf_nxt[k*DCT_ATOM_W +: DCT_ATOM_W] = atom_data;
          end
          w_cnt_nxt = r_cnt + DCT_CNT_W'(1);
        end
        w_close = (atom_valid && (r_cnt == DCT_CNT_W'(DCT_DEPTH - 1))) ||
                  ((atom_valid || (r_state == ST_FILL)) && (flush || w_ending));
        if (w_close)                              w_state_nxt = ST_HOLD;
        else if (atom_valid)                      w_state_nxt = ST_FILL;
        else if (r_state == ST_EMPTY && w_ending) w_state_nxt = ST_DONE;
      end
      ST_HOLD: begin
        if (dct_ready) begin
          w_buf_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = w_ending ? ST_DONE : ST_EMPTY;
        end
      end
      default: ;
    endcase
  end

  // Registered frame, handshake and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf            <= '0;
      r_cnt            <= '0;
      r_ending         <= 1'b0;
      r_dct_valid      <= 1'b0;
      r_test_has_ended <= 1'b0;
    end else begin
      r_buf            <= w_buf_nxt;
      r_cnt            <= w_cnt_nxt;
      r_ending         <= w_ending;
      r_dct_valid      <= (w_state_nxt == ST_HOLD);
      r_test_has_ended <= r_test_has_ended | (w_state_nxt == ST_DONE);
    end
  end

  assign dct_valid      = r_dct_valid;
  assign dct_buffer     = r_buf;
  assign dct_count      = r_cnt;
  assign test_has_ended = r_test_has_ended;

`ifdef DCT_DROP_CNT_EN
  logic                  w_drop;
  logic [DCT_DROP_W-1:0] r_dropped_cnt;

  assign w_drop = atom_valid && ((r_state == ST_HOLD) || (r_state == ST_DONE));

  // Saturating count of atoms lost while a frame is held or after the test ended.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                    r_dropped_cnt <= '0;
    else if (w_drop && (r_dropped_cnt != '1))        r_dropped_cnt <= r_dropped_cnt + DCT_DROP_W'(1);
  end

  assign dropped_cnt = r_dropped_cnt;
`endif

endmodule

// File: tb/tb_embcpu8k_nios2_qsys_0_oci_dct_packer.sv
// Self-checking bench for the OCI trace packer: vector table, directed corners, random vs. queue model.
module tb_embcpu8k_nios2_qsys_0_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        atom_valid = 1'b0;
  logic [1:0]  atom_data = 2'd0;
  logic        flush = 1'b0;
  logic        test_ending = 1'b0;
  logic        dct_ready = 1'b0;
  logic        dct_valid;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_has_ended;
`ifdef DCT_DROP_CNT_EN
  logic [7:0]  dropped_cnt;
`endif

  embcpu8k_nios2_qsys_0_oci_dct_packer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .atom_valid     (atom_valid),
    .atom_data      (atom_data),
    .flush          (flush),
    .test_ending    (test_ending),
    .dct_ready      (dct_ready),
    .dct_valid      (dct_valid),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
`ifdef DCT_DROP_CNT_EN
    .dropped_cnt    (dropped_cnt),
`endif
    .test_has_ended (test_has_ended)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: the open frame is a queue of atoms.
  int m_q[$];
  bit m_hold, m_done, m_end;
  int m_drop;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic logic [29:0] model_buf();
    logic [29:0] b = '0;
    foreach (m_q[k]) b = b | (30'(m_q[k]) << (2 * k));
    return b;
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_hold = 0; m_done = 0; m_end = 0; m_drop = 0;
  endfunction

  function automatic void model_step();
    if (m_done) begin
      if (atom_valid) m_drop++;
    end else if (m_hold) begin
      if (atom_valid) m_drop++;
      m_end = m_end | test_ending;
      if (dct_ready) begin
        m_q.delete();
        m_hold = 0;
        if (m_end) m_done = 1;
      end
    end else begin
      m_end = m_end | test_ending;
      if (atom_valid) m_q.push_back(int'(atom_data));
      if (m_q.size() > 0 && (m_q.size() == 15 || flush || m_end)) m_hold = 1;
      else if (m_q.size() == 0 && m_end) m_done = 1;
    end
    if (m_drop > 255) m_drop = 255;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_valid"}, 32'(dct_valid), 32'(m_hold));
    chk({tag, "_count"}, 32'(dct_count), 32'(m_q.size()));
    chk({tag, "_buffer"}, 32'(dct_buffer), 32'(model_buf()));
    chk({tag, "_ended"}, 32'(test_has_ended), 32'(m_done));
`ifdef DCT_DROP_CNT_EN
    chk({tag, "_dropped"}, 32'(dropped_cnt), 32'(m_drop));
`endif
  endtask

  // One clock: drive after the falling edge, model at the rising edge, check at the next falling edge.
  task automatic cyc(input bit av, input logic [1:0] ad, input bit fl, input bit te, input bit rdy,
                     input string tag);
    atom_valid = av; atom_data = ad; flush = fl; test_ending = te; dct_ready = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    atom_valid = 0; flush = 0; test_ending = 0; dct_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit av; logic [1:0] ad; bit fl; bit te; bit rdy;
    bit ev; logic [3:0] ec; logic [29:0] eb;
  } vec_t;
  vec_t tbl[10];

  initial begin
    int vcycles;
    // 3 atoms, flush, 5 stalled cycles, then handoff
    tbl[0] = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 30'h3};
    tbl[1] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 30'h3};
    tbl[2] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 30'h13};
    tbl[3] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 30'h13};
    tbl[4] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 30'h13};
    tbl[5] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 30'h13};
    tbl[6] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 30'h13};
    tbl[7] = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 30'h13};
    tbl[8] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 30'h13};
    tbl[9] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 30'h0};

    do_reset();
    // flush in EMPTY with no atom is ignored
    cyc(0, 2'd0, 1, 0, 1, "empty_flush");
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].av, tbl[i].ad, tbl[i].fl, tbl[i].te, tbl[i].rdy, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_vec_valid", i), 32'(dct_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_vec_count", i), 32'(dct_count), 32'(tbl[i].ec));
      chk($sformatf("tbl%0d_vec_buffer", i), 32'(dct_buffer), 32'(tbl[i].eb));
    end

    // 15 atoms 0,1,2,3,... with ready high: one full frame, valid for one cycle
    do_reset();
    vcycles = 0;
    for (int i = 0; i < 15; i++) begin
      cyc(1, 2'(i % 4), 0, 0, 1, "full");
      if (dct_valid) vcycles++;
    end
    chk("full_count", 32'(dct_count), 32'd15);
    chk("full_buffer", 32'(dct_buffer), 32'h24E4E4E4);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 2'd0, 0, 0, 1, "full_drain");
      if (dct_valid) vcycles++;
    end
    chk("full_valid_cycles", 32'(vcycles), 32'd1);

    // atom and flush together at count 5
    do_reset();
    cyc(1, 2'd1, 0, 0, 0, "af"); cyc(1, 2'd2, 0, 0, 0, "af"); cyc(1, 2'd3, 0, 0, 0, "af");
    cyc(1, 2'd1, 0, 0, 0, "af"); cyc(1, 2'd2, 0, 0, 0, "af");
    cyc(1, 2'd3, 1, 0, 0, "af_close");
    chk("af_count", 32'(dct_count), 32'd6);
    chk("af_buffer", 32'(dct_buffer), 32'hE79);
    chk("af_valid", 32'(dct_valid), 32'd1);

`ifdef DCT_DROP_CNT_EN
    // drops while held, then saturation
    for (int i = 0; i < 4; i++) cyc(1, 2'd0, 0, 0, 0, "drop");
    chk("drop_cnt4", 32'(dropped_cnt), 32'd4);
    chk("drop_frame", 32'(dct_buffer), 32'hE79);
    for (int i = 0; i < 300; i++) cyc(1, 2'(i), 0, 0, 0, "drop_sat");
    chk("drop_sat", 32'(dropped_cnt), 32'd255);
`endif

    // test_ending at count 2
    do_reset();
    cyc(1, 2'd2, 0, 0, 0, "end"); cyc(1, 2'd1, 0, 0, 0, "end");
    cyc(0, 2'd0, 0, 1, 0, "end_req");
    chk("end_hold_count", 32'(dct_count), 32'd2);
    chk("end_hold_valid", 32'(dct_valid), 32'd1);
    cyc(0, 2'd0, 0, 0, 1, "end_handoff");
    chk("end_has_ended", 32'(test_has_ended), 32'd1);
    vcycles = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1, 2'(i), (i % 2) == 1, 0, 1, "end_after");
      if (dct_valid) vcycles++;
    end
    chk("end_no_valid", 32'(vcycles), 32'd0);
    chk("end_sticky", 32'(test_has_ended), 32'd1);

    // asynchronous reset while holding a frame
    do_reset();
    cyc(1, 2'd3, 1, 0, 0, "ar_fill");
    chk("ar_pre_valid", 32'(dct_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_async_valid", 32'(dct_valid), 32'd0);
    chk("ar_async_count", 32'(dct_count), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1, 2'd2, 0, 0, 0, "ar_after");
    chk("ar_empty_accepts", 32'(dct_count), 32'd1);

    // randomized traffic against the queue model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else cyc(($urandom % 4) != 0, 2'($urandom), ($urandom % 16) == 0,
               ($urandom % 128) == 0, ($urandom % 3) != 0, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
